// File: rtl/multi_debouncer.sv
// -----------------------------------------------------------------------------
// multi_debouncer
//   N-channel push-button conditioner. Each channel has a 2-FF synchroniser, a
//   counter debouncer, registered press/release pulses, a long-press detector
//   and an optional auto-repeat generator. Channels are fully independent.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   pb_in      [N_CH] raw asynchronous button inputs
//   pb_state   [N_CH] debounced level, 1 = pressed
//   pb_down    [N_CH] one-cycle pulse on debounced press
//   pb_up      [N_CH] one-cycle pulse on debounced release
//   pb_hold    [N_CH] one-cycle pulse once a press has lasted HOLD_CNT cycles
//   pb_repeat  [N_CH] one-cycle pulse every REPEAT_CNT cycles after pb_hold
//   pb_any     OR of pb_state
// -----------------------------------------------------------------------------
module multi_debouncer #(
  parameter int N_CH       = 4,
  parameter int ACTIVE_LOW = 1,
  parameter int DB_CNT     = 65535,
  parameter int HOLD_CNT   = 50000000,
  parameter int REPEAT_CNT = 10000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] pb_in,
  output logic [N_CH-1:0] pb_state,
  output logic [N_CH-1:0] pb_down,
  output logic [N_CH-1:0] pb_up,
  output logic [N_CH-1:0] pb_hold,
  output logic [N_CH-1:0] pb_repeat,
  output logic            pb_any
);

  localparam int DB_W   = $clog2(DB_CNT + 1);
  localparam int HC_MAX = (HOLD_CNT > REPEAT_CNT) ? HOLD_CNT : REPEAT_CNT;
  localparam int HC_W   = $clog2(HC_MAX + 1);

  localparam logic            INV    = (ACTIVE_LOW != 0);
  localparam logic            REP_EN = (REPEAT_CNT > 0);
  localparam logic [DB_W-1:0] DB_TC  = DB_W'(DB_CNT);
  // Hold/repeat counters count from the pulse cycle (value 0), so the terminal
  // value is one less than the period.
  localparam logic [HC_W-1:0] HOLD_TC = HC_W'(HOLD_CNT - 1);
  localparam logic [HC_W-1:0] REP_TC  = HC_W'(REP_EN ? (REPEAT_CNT - 1) : 0);

  typedef enum logic {
    PH_HOLD   = 1'b0,
    PH_REPEAT = 1'b1
  } phase_e;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic            sync_p0;
    logic            sync_p1;
    logic [DB_W-1:0] db_cnt;
    logic [DB_W-1:0] db_cnt_nxt;
    logic            state;
    logic            state_nxt;
    logic            down_r;
    logic            down_nxt;
    logic            up_r;
    logic            up_nxt;
    logic [HC_W-1:0] hc_cnt;
    logic [HC_W-1:0] hc_cnt_nxt;
    phase_e          phase;
    phase_e          phase_nxt;
    logic            hold_r;
    logic            hold_nxt;
    logic            rep_r;
    logic            rep_nxt;

    // Stage p0/p1: normalise to 1 = pressed, then two-flop synchroniser.
    // Reset value 0 is the released level, so no edge fires out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_p0 <= 1'b0;
        sync_p1 <= 1'b0;
      end else begin
        sync_p0 <= pb_in[g] ^ INV;
        sync_p1 <= sync_p0;
      end
    end

    // Debounce: the debounced level flips only after DB_CNT+1 consecutive
    // samples disagree with it; any agreeing sample restarts the count.
    always_comb begin
      db_cnt_nxt = db_cnt;
      state_nxt  = state;
      down_nxt   = 1'b0;
      up_nxt     = 1'b0;
      if (sync_p1 == state) begin
        db_cnt_nxt = '0;
      end else if (db_cnt == DB_TC) begin
        db_cnt_nxt = '0;
        state_nxt  = ~state;
        down_nxt   = ~state;
        up_nxt     = state;
      end else begin
        db_cnt_nxt = db_cnt + DB_W'(1);
      end
    end

    // Hold/repeat phase machine. It only advances while the button stays
    // pressed across this edge, so a pulse can never coincide with pb_up.
    always_comb begin
      hc_cnt_nxt = '0;
      phase_nxt  = PH_HOLD;
      hold_nxt   = 1'b0;
      rep_nxt    = 1'b0;
      if (state && state_nxt) begin
        hc_cnt_nxt = hc_cnt;
        phase_nxt  = phase;
        if (phase == PH_HOLD) begin
          if (hc_cnt == HOLD_TC) begin
            hold_nxt   = 1'b1;
            hc_cnt_nxt = '0;
            phase_nxt  = PH_REPEAT;
          end else begin
            hc_cnt_nxt = hc_cnt + HC_W'(1);
          end
        end else if (REP_EN) begin
          if (hc_cnt == REP_TC) begin
            rep_nxt    = 1'b1;
            hc_cnt_nxt = '0;
          end else begin
            hc_cnt_nxt = hc_cnt + HC_W'(1);
          end
        end
      end
    end

    // Stage p2: debounced level, counters and registered event pulses.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db_cnt <= '0;
        state  <= 1'b0;
        down_r <= 1'b0;
        up_r   <= 1'b0;
        hc_cnt <= '0;
        phase  <= PH_HOLD;
        hold_r <= 1'b0;
        rep_r  <= 1'b0;
      end else begin
        db_cnt <= db_cnt_nxt;
        state  <= state_nxt;
        down_r <= down_nxt;
        up_r   <= up_nxt;
        hc_cnt <= hc_cnt_nxt;
        phase  <= phase_nxt;
        hold_r <= hold_nxt;
        rep_r  <= rep_nxt;
      end
    end

    assign pb_state[g]  = state;
    assign pb_down[g]   = down_r;
    assign pb_up[g]     = up_r;
    assign pb_hold[g]   = hold_r;
    assign pb_repeat[g] = rep_r;
  end : g_ch

  assign pb_any = |pb_state;

endmodule

// File: tb/tb_multi_debouncer.sv
module tb_multi_debouncer;

  localparam int K_DN = 0;
  localparam int K_UP = 1;
  localparam int K_HD = 2;
  localparam int K_RP = 3;

  logic       clk;
  logic       rst_n;
  logic [1:0] pb_in;
  logic [1:0] pb_state;
  logic [1:0] pb_down;
  logic [1:0] pb_up;
  logic [1:0] pb_hold;
  logic [1:0] pb_repeat;
  logic       pb_any;

  multi_debouncer #(
    .N_CH(2), .ACTIVE_LOW(1), .DB_CNT(4), .HOLD_CNT(10), .REPEAT_CNT(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pb_in(pb_in), .pb_state(pb_state),
    .pb_down(pb_down), .pb_up(pb_up), .pb_hold(pb_hold),
    .pb_repeat(pb_repeat), .pb_any(pb_any)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int ch;
    int kind;
  } ev_t;

  ev_t        exp_q[$];
  logic [1:0] exp_state = 2'b00;
  int         total = 0;
  int         bad = 0;
  logic [10:0] obs;
  logic [10:0] expv;

  task automatic push_ev(input int c, input int ch, input int kind);
    ev_t e;
    e.cyc  = c;
    e.ch   = ch;
    e.kind = kind;
    exp_q.push_back(e);
  endtask

  // Press whose pb_down lands on cycle d and pb_up on cycle u.
  task automatic push_press(input int ch, input int d, input int u);
    push_ev(d, ch, K_DN);
    if (d + 10 < u) begin
      push_ev(d + 10, ch, K_HD);
      for (int r = d + 13; r < u; r += 3) push_ev(r, ch, K_RP);
    end
    push_ev(u, ch, K_UP);
  endtask

  task automatic pop_exp(input int c, output logic [10:0] v);
    logic [1:0] dn, up, hd, rp;
    dn = '0; up = '0; hd = '0; rp = '0;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == c) begin
        case (exp_q[i].kind)
          K_DN:    dn[exp_q[i].ch] = 1'b1;
          K_UP:    up[exp_q[i].ch] = 1'b1;
          K_HD:    hd[exp_q[i].ch] = 1'b1;
          default: rp[exp_q[i].ch] = 1'b1;
        endcase
        exp_q.delete(i);
      end
    end
    exp_state = (exp_state | dn) & ~up;
    v = {|exp_state, exp_state, rp, hd, up, dn};
  endtask

  task automatic test_reset;
    int c0;
    pb_in = 2'b00;
    rst_n = 1'b0;
    exp_q.delete();
    exp_state = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      obs = {pb_any, pb_state, pb_repeat, pb_hold, pb_up, pb_down};
      total++;
      if (obs !== 11'd0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got=%b want=%b", cyc, obs, 11'd0);
      end
    end
    rst_n = 1'b1;
    c0 = cyc;
    push_press(0, c0 + 7, c0 + 16);
    push_press(1, c0 + 7, c0 + 16);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      pop_exp(cyc, expv);
      obs = {pb_any, pb_state, pb_repeat, pb_hold, pb_up, pb_down};
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL reset_release cyc=%0d got=%b want=%b", cyc, obs, expv);
      end
      if (cyc - c0 == 9) pb_in = 2'b11;
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL reset_pending got=%0d want=0", exp_q.size());
    end
  endtask

  task automatic test_bounce;
    int c0;
    c0 = cyc;
    pb_in[0] = 1'b0;
    push_press(0, c0 + 28, c0 + 38);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      pop_exp(cyc, expv);
      obs = {pb_any, pb_state, pb_repeat, pb_hold, pb_up, pb_down};
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL bounce cyc=%0d got=%b want=%b", cyc, obs, expv);
      end
      case (cyc - c0)
        4, 11, 18, 31: pb_in[0] = 1'b1;
        7, 14, 21:     pb_in[0] = 1'b0;
        default: ;
      endcase
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL bounce_pending got=%0d want=0", exp_q.size());
    end
  endtask

  task automatic test_short_press;
    int c0;
    c0 = cyc;
    pb_in = 2'b10;
    push_press(0, c0 + 7, c0 + 15);
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      pop_exp(cyc, expv);
      obs = {pb_any, pb_state, pb_repeat, pb_hold, pb_up, pb_down};
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL short_press cyc=%0d got=%b want=%b", cyc, obs, expv);
      end
      if (cyc - c0 == 8) pb_in = 2'b11;
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL short_pending got=%0d want=0", exp_q.size());
    end
  endtask

  task automatic test_long_press;
    int c0;
    c0 = cyc;
    pb_in = 2'b10;
    // Release lands pb_up on a cycle where a repeat would otherwise fall.
    push_press(0, c0 + 7, c0 + 35);
    for (int i = 1; i <= 42; i++) begin
      @(negedge clk);
      pop_exp(cyc, expv);
      obs = {pb_any, pb_state, pb_repeat, pb_hold, pb_up, pb_down};
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL long_press cyc=%0d got=%b want=%b", cyc, obs, expv);
      end
      if (cyc - c0 == 28) pb_in = 2'b11;
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL long_pending got=%0d want=0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_hold;
    int c0;
    int r;
    c0 = cyc;
    pb_in = 2'b01;
    push_ev(c0 + 7, 1, K_DN);
    push_ev(c0 + 17, 1, K_HD);
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      pop_exp(cyc, expv);
      obs = {pb_any, pb_state, pb_repeat, pb_hold, pb_up, pb_down};
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL mid_hold cyc=%0d got=%b want=%b", cyc, obs, expv);
      end
    end
    rst_n = 1'b0;
    #1;
    obs = {pb_any, pb_state, pb_repeat, pb_hold, pb_up, pb_down};
    total++;
    if (obs !== 11'd0) begin
      bad++;
      $display("FAIL async_reset got=%b want=%b", obs, 11'd0);
    end
    exp_q.delete();
    exp_state = 2'b00;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      pop_exp(cyc, expv);
      obs = {pb_any, pb_state, pb_repeat, pb_hold, pb_up, pb_down};
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL in_reset cyc=%0d got=%b want=%b", cyc, obs, expv);
      end
    end
    rst_n = 1'b1;
    r = cyc;
    push_press(1, r + 7, r + 16);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      pop_exp(cyc, expv);
      obs = {pb_any, pb_state, pb_repeat, pb_hold, pb_up, pb_down};
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL fresh_press cyc=%0d got=%b want=%b", cyc, obs, expv);
      end
      if (cyc - r == 9) pb_in = 2'b11;
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL reset_mid_pending got=%0d want=0", exp_q.size());
    end
  endtask

  task automatic test_glitch;
    int c0;
    c0 = cyc;
    pb_in = 2'b01;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      pop_exp(cyc, expv);
      obs = {pb_any, pb_state, pb_repeat, pb_hold, pb_up, pb_down};
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL glitch cyc=%0d got=%b want=%b", cyc, obs, expv);
      end
      if (cyc - c0 == 3) pb_in = 2'b11;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pb_in = 2'b11;
    test_reset();
    test_bounce();
    test_short_press();
    test_long_press();
    test_reset_mid_hold();
    test_glitch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
